// File: rtl/tribus_controller_pkg.sv
// Shared types, constants and counter sizing for the tristate bus controller.
package tribus_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} tribus_state_t;

  localparam int DEF_N      = 4;
  localparam int DEF_W      = 1;
  localparam int DEF_SETTLE = 2;
  localparam int DEF_TURN   = 1;

  // The counter only ever holds SETTLE-1 or TURN-1, so size it for the larger.
  function automatic int cnt_w(input int settle, input int turn);
    int m;
    m = (settle > turn) ? settle : turn;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tribus_controller_if.sv
// Driver requests/enables, resolved bus value and the captured-word output port.
interface tribus_controller_if import tribus_pkg::*; #(
  parameter int N = DEF_N,
  parameter int W = DEF_W
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [W-1:0]  bus_in;
  logic [N-1:0]  en;
  logic [W-1:0]  dout;
  logic [IW-1:0] dout_src;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;

  modport master (
    input  req, bus_in, dout_ready,
    output en, dout, dout_src, dout_valid, busy
  );

  modport slave (
    output req, bus_in, dout_ready,
    input  en, dout, dout_src, dout_valid, busy
  );
endinterface

// File: rtl/tribus_controller_rr_arbiter.sv
// Round-robin pick of one request, searching upward from ptr with wrap.
// Latency: combinational.
// Backpressure: none; go=0 suppresses every grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          go,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (go && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/tribus_controller.sv
// Tristate bus owner: grants one driver enable, waits SETTLE, samples, then holds a TURN gap.
// Latency: word valid SETTLE+1 cycles after req seen in IDLE; next enable no earlier than SETTLE+TURN+2.
// Backpressure: single-word output slot; arbitration stalls in IDLE while the slot is full and unconsumed.
module tribus_controller import tribus_pkg::*; #(
  parameter int N      = DEF_N,
  parameter int W      = DEF_W,
  parameter int SETTLE = DEF_SETTLE,
  parameter int TURN   = DEF_TURN
) (
  input logic                 clk,
  input logic                 rst,
  tribus_controller_if.master io
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = cnt_w(SETTLE, TURN);

  tribus_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] g_q, g_d;
  logic [N-1:0]  en_q, en_d;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic [W-1:0]  dout_q;
  logic [IW-1:0] src_q;
  logic          vld_q;
  logic          cap;
  logic          go;

  // Slot is free if empty or being drained on this very edge.
  assign go = (state_q == IDLE) && (!vld_q || io.dout_ready);

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req       (io.req),
    .ptr       (ptr_q),
    .go        (go),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    en_d    = en_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d = DRIVE;
          en_d    = grant;
          g_d     = grant_idx;
          cnt_d   = CW'(SETTLE - 1);
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          cap     = 1'b1;
          en_d    = '0;
          ptr_d   = (g_q == IW'(N - 1)) ? '0 : g_q + 1'b1;
          cnt_d   = CW'(TURN - 1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      g_q     <= '0;
      en_q    <= '0;
      dout_q  <= '0;
      src_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      en_q    <= en_d;
      if (cap) begin
        dout_q <= io.bus_in;
        src_q  <= g_q;
        vld_q  <= 1'b1;
      end else if (vld_q && io.dout_ready) begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign io.en         = en_q;
  assign io.dout       = dout_q;
  assign io.dout_src   = src_q;
  assign io.dout_valid = vld_q;
  assign io.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tribus_controller.sv
// Directed bench: default-parameter instance plus a SETTLE=4/TURN=3 instance.
module tb_tribus_controller;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  tribus_controller_if #(.N(4), .W(1)) ba ();
  tribus_controller_if #(.N(4), .W(1)) bb ();

  tribus_controller #(.N(4), .W(1), .SETTLE(2), .TURN(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .io  (ba)
  );

  tribus_controller #(.N(4), .W(1), .SETTLE(4), .TURN(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .io  (bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] e;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    ba.req = '0; ba.bus_in = '0; ba.dout_ready = 1'b1;
    bb.req = '0; bb.bus_in = '0; bb.dout_ready = 1'b1;
    tick();
    tick();

    chk("rst_en",    ba.en, 0);
    chk("rst_valid", ba.dout_valid, 0);
    chk("rst_dout",  ba.dout, 0);
    chk("rst_src",   ba.dout_src, 0);
    chk("rst_busy",  ba.busy, 0);
    chk("rst_en_b",  bb.en, 0);

    // Single request, cycle 0
    rst = 1'b0;
    ba.req = 4'b0100; ba.bus_in = 1'b1;
    tick();
    chk("single_en_c1", ba.en, 4'b0100);
    chk("single_busy_c1", ba.busy, 1);
    ba.req = '0;
    tick();
    chk("single_en_c2", ba.en, 4'b0100);
    tick();
    chk("single_en_c3", ba.en, 0);
    chk("single_valid_c3", ba.dout_valid, 1);
    chk("single_dout_c3", ba.dout, 1);
    chk("single_src_c3", ba.dout_src, 2);
    tick();
    chk("single_en_c4", ba.en, 0);
    chk("single_valid_c4", ba.dout_valid, 0);
    chk("single_busy_c4", ba.busy, 0);

    // Round-robin from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ba.req = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      int p;
      int ph;
      tick();
      p  = (k - 1) / 4;
      ph = (k - 1) % 4;
      e  = (ph < 2) ? (32'd1 << (p % 4)) : 32'd0;
      chk("rr_en", ba.en, e);
      if (ph == 2) chk("rr_src", ba.dout_src, p % 4);
    end
    ba.req = '0;

    // Backpressure
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ba.req = 4'b0011; ba.dout_ready = 1'b0; ba.bus_in = 1'b1;
    tick();
    chk("bp_en_c1", ba.en, 4'b0001);
    tick();
    tick();
    chk("bp_valid_c3", ba.dout_valid, 1);
    chk("bp_src_c3", ba.dout_src, 0);
    for (int k = 4; k <= 7; k++) begin
      tick();
      chk("bp_stall_en", ba.en, 0);
      chk("bp_hold_valid", ba.dout_valid, 1);
      chk("bp_hold_src", ba.dout_src, 0);
      chk("bp_hold_dout", ba.dout, 1);
    end
    ba.dout_ready = 1'b1;
    tick();
    chk("bp_grant1_en", ba.en, 4'b0010);
    chk("bp_drained", ba.dout_valid, 0);
    ba.req = '0; ba.bus_in = 1'b0;
    tick();
    tick();
    chk("bp_src1", ba.dout_src, 1);
    chk("bp_dout1", ba.dout, 0);
    chk("bp_valid1", ba.dout_valid, 1);

    // Request withdrawn during DRIVE
    tick();
    ba.req = 4'b0010; ba.bus_in = 1'b1;
    tick();
    chk("wd_en_c1", ba.en, 4'b0010);
    ba.req = '0;
    tick();
    chk("wd_en_c2", ba.en, 4'b0010);
    tick();
    chk("wd_valid", ba.dout_valid, 1);
    chk("wd_src", ba.dout_src, 1);
    chk("wd_dout", ba.dout, 1);

    // Reset mid-drive
    tick();
    ba.req = 4'b0100;
    tick();
    chk("rmd_en_drive", ba.en, 4'b0100);
    rst = 1'b1; ba.req = 4'b1000;
    tick();
    chk("rmd_en", ba.en, 0);
    chk("rmd_valid", ba.dout_valid, 0);
    chk("rmd_busy", ba.busy, 0);
    rst = 1'b0; ba.bus_in = 1'b0;
    tick();
    chk("rmd_grant3", ba.en, 4'b1000);
    ba.req = '0;
    tick();
    tick();
    chk("rmd_src3", ba.dout_src, 3);
    chk("rmd_dout", ba.dout, 0);

    // SETTLE=4, TURN=3 instance
    bb.req = 4'b0001; bb.bus_in = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      e = (k <= 4 || k == 9) ? 32'd1 : 32'd0;
      chk("sw_en", bb.en, e);
      if (k == 4) bb.bus_in = 1'b1;
      if (k == 5) begin
        chk("sw_valid", bb.dout_valid, 1);
        chk("sw_dout", bb.dout, 1);
        chk("sw_src", bb.dout_src, 0);
        bb.bus_in = 1'b0;
      end
    end
    bb.req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
